// File: rtl/uart_rx_ctrl.sv
// -----------------------------------------------------------------------------
// uart_rx_ctrl
//   Receive-side frame controller for the UART. Uses the half-bit ticks and
//   enable from the RX tick generator to sample the start, data and stop bits,
//   then pulses a stop request that shuts the tick generator down. Received
//   bytes go into a one-entry holding register with a valid/ready handshake.
//   The controller also reports framing errors and overruns.
//
// Parameters
//   DATA_BITS      data bits per frame, LSB first on the line (5..8)
//
// Ports
//   iCLK           system clock
//   iRESETn        asynchronous active-low reset
//   iUART_RX       serial line, idle high
//   iUART_RX_TICK  half-bit tick; first pulse lands mid start bit
//   iUART_RX_EN    tick generator enable; rises one cycle after the start edge
//   oUART_RX_STOP  one-cycle request that clears the tick generator enable
//   oRX_DATA       received byte, stable while oRX_VALID is high
//   oRX_VALID      holding register full
//   iRX_READY      consumer accepts when oRX_VALID & iRX_READY
//   oRX_FERR       framing error (stop bit sampled low) for oRX_DATA
//   oRX_OVERRUN    one-cycle pulse: a completed frame was dropped
//   oRX_BUSY       frame in progress
// -----------------------------------------------------------------------------
module uart_rx_ctrl #(
    parameter int DATA_BITS = 8
) (
    input  logic                 iCLK,
    input  logic                 iRESETn,
    input  logic                 iUART_RX,
    input  logic                 iUART_RX_TICK,
    input  logic                 iUART_RX_EN,
    output logic                 oUART_RX_STOP,
    output logic [DATA_BITS-1:0] oRX_DATA,
    output logic                 oRX_VALID,
    input  logic                 iRX_READY,
    output logic                 oRX_FERR,
    output logic                 oRX_OVERRUN,
    output logic                 oRX_BUSY
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DONE
    } state_e;

    // Tick index of the mid-stop-bit sample, and the index of the last data bit.
    localparam logic [4:0] K_STOP   = 5'(2 * DATA_BITS + 3);
    localparam logic [2:0] BIT_LAST = 3'(DATA_BITS - 1);

    state_e               state_q, state_d;
    logic [4:0]           k_q, k_d;
    logic [2:0]           bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 ferr_q, ferr_d;
    logic                 over_q, over_d;
    logic                 stop_q, busy_q;

    // The tick index that the current tick would produce. Sampling decisions
    // use this value so that "k=1" means the first tick of the frame.
    logic [4:0] k_inc;
    logic       in_frame;
    logic       start_sample;
    logic       shift_en;
    logic       stop_sample;

    assign k_inc        = k_q + 5'd1;
    assign in_frame     = (state_q == START) || (state_q == DATA) || (state_q == STOP);
    assign start_sample = (state_q == START) && iUART_RX_EN && iUART_RX_TICK
                          && (k_inc == 5'd1);
    assign shift_en     = (state_q == DATA) && iUART_RX_EN && iUART_RX_TICK && k_inc[0];
    assign stop_sample  = (state_q == STOP) && iUART_RX_EN && iUART_RX_TICK
                          && (k_inc == K_STOP);

    // ---------------------------------------------------------------- state reg
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of process evaluation order.
    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // --------------------------------------------------------------- next state
    // An enable that drops while a frame is in flight was not requested by us,
    // so the frame is abandoned without a stop pulse.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_d unassigned,
        // which would otherwise infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:  if (iUART_RX_EN) state_d = START;
            START: begin
                if (!iUART_RX_EN)     state_d = IDLE;
                else if (start_sample) state_d = iUART_RX ? DONE : DATA;
            end
            DATA: begin
                if (!iUART_RX_EN)                         state_d = IDLE;
                else if (shift_en && (bit_q == BIT_LAST)) state_d = STOP;
            end
            STOP: begin
                if (!iUART_RX_EN)     state_d = IDLE;
                else if (stop_sample) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------ datapath / outputs
    always_comb begin
        k_d     = k_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = ferr_q;
        over_d  = 1'b0;

        if (state_q == IDLE) begin
            k_d   = '0;
            bit_d = '0;
        end else if (in_frame && iUART_RX_TICK) begin
            k_d = k_inc;
        end

        // LSB arrives first, so each new bit enters at the MSB and moves down.
        if (shift_en) begin
            shift_d = {iUART_RX, shift_q[DATA_BITS-1:1]};
            bit_d   = bit_q + 3'd1;
        end

        // A load on the same edge as an accept wins, so VALID stays high.
        if (stop_sample) begin
            if (!valid_q || iRX_READY) begin
                data_d  = shift_q;
                ferr_d  = ~iUART_RX;
                valid_d = 1'b1;
            end else begin
                over_d  = 1'b1;
            end
        end else if (valid_q && iRX_READY) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge iCLK or negedge iRESETn) begin
        if (!iRESETn) begin
            k_q     <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            over_q  <= 1'b0;
            stop_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            k_q     <= k_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            over_q  <= over_d;
            // Decoded from the next state so both flags come straight off flops.
            stop_q  <= (state_d == DONE);
            busy_q  <= (state_d != IDLE);
        end
    end

    assign oUART_RX_STOP = stop_q;
    assign oRX_DATA      = data_q;
    assign oRX_VALID     = valid_q;
    assign oRX_FERR      = ferr_q;
    assign oRX_OVERRUN   = over_q;
    assign oRX_BUSY      = busy_q;

endmodule
